// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmitter and receiver:
//                frame state encoding, default line settings and the
//                clock-cycles-per-bit computation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Frame states; PARITY is only reachable when parity generation is built in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int DEFAULT_BAUD_RATE = 9_600;
    localparam int DATA_BITS         = 8;
    localparam int BAUD_CNT_W        = 14;

    // Clock cycles spent on one bit of the serial line
    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period divider. Counts 0..DIVISOR-1 and flags the last
//                count with a one-cycle bit_tick_o; clear_i restarts the
//                period so a new frame begins on a whole bit boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen #(
    parameter int DIVISOR = 10416,
    parameter int CNT_W   = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick_o = (cnt_q == c_LAST);

    // Next count: restart on clear or at the end of each bit period
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. Accepts one byte per valid/ready handshake
//                and serialises it as start bit, 8 data bits LSB first,
//                optional even parity bit, then STOP_BITS stop bits.
//                Build option: define UART_TX_PARITY_EN for 8E1 framing;
//                without it the frame is 8N1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       busy,
    output logic       tx_done
);

    localparam int         BAUD_DIV    = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] c_LAST_DATA = 3'(DATA_BITS - 1);
    // Only 1 or 2 stop bits are meaningful; anything else behaves as 1
    localparam logic [2:0] c_LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    uart_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        txd_q, txd_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_clr;
    logic        bit_tick;
    logic        accept;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    assign accept = tx_valid && ready_q;

    uart_baud_gen #(
        .DIVISOR (BAUD_DIV),
        .CNT_W   (BAUD_CNT_W)
    ) u_baud_gen (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (baud_clr),
        .bit_tick_o (bit_tick)
    );

    // Frame sequencing: next state, shift register and bit counter
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        baud_clr = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    shreg_d  = tx_data;
                    bitcnt_d = 3'd0;
                    baud_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bitcnt_q == c_LAST_DATA) begin
                        bitcnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
`else
                        state_d  = STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (bitcnt_q == c_LAST_STOP) begin
                        state_d  = IDLE;
                        bitcnt_d = 3'd0;
                        done_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level and status flags follow the next state so they change on
    // the same edge as the state register and leave the flops glitch-free
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_q;
`endif
            default: txd_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= 8'h00;
            bitcnt_q <= 3'd0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign TxD      = txd_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Expected line waveforms are
//                built from the frame format (start, data LSB first, parity,
//                stop) and compared cycle by cycle and at mid-bit points.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
    localparam int BD        = CLK_FREQ / BAUD_RATE;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int NB        = 1 + 8 + PAR_BITS + STOP_BITS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       TxD;
    logic       busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;
    int fr      = 0;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .TxD      (TxD),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: index k is the line level during bit period k
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic par);
        logic [15:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
        if (PAR_BITS == 1) b[9] = par;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (TxD !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
            tick();
        end
        chk(name, bad, 0);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (tx_ready !== 1'b1 && k < 4 * NB * BD) begin
            tick();
            k++;
        end
        chk("ready_wait", tx_ready, 1);
    endtask

    // Present a byte; returns one cycle after the handshake edge (offset 0)
    task automatic start_frame(input logic [7:0] d);
        wait_ready();
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
    endtask

    // mode 0: drop valid; 1: hold valid with nxt; 2: pulse 0x33 mid-frame
    task automatic run_frame(input logic [7:0] d, input logic par, input int mode,
                             input logic [7:0] nxt);
        logic [15:0] bits;
        int bad_txd, bad_rdy, bad_busy, bad_done;
        bits = frame_bits(d, par);
        bad_txd = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
        for (int c = 0; c <= NB * BD; c++) begin
            case (mode)
                1: begin tx_valid = 1'b1; tx_data = nxt; end
                2: begin tx_valid = (c == 3 * BD); tx_data = 8'h33; end
                default: tx_valid = 1'b0;
            endcase
            if (c < NB * BD) begin
                if (TxD !== bits[c / BD]) bad_txd++;
                if (tx_ready !== 1'b0) bad_rdy++;
                if (busy !== 1'b1) bad_busy++;
                if (tx_done !== 1'b0) bad_done++;
                if (c % BD == BD / 2)
                    chk($sformatf("f%0d_bit%0d", fr, c / BD), TxD, bits[c / BD]);
            end else begin
                chk($sformatf("f%0d_done_pulse", fr), tx_done, 1);
                chk($sformatf("f%0d_ready_back", fr), tx_ready, 1);
                chk($sformatf("f%0d_idle_txd", fr), TxD, 1);
            end
            tick();
        end
        chk($sformatf("f%0d_txd_shape", fr), bad_txd, 0);
        chk($sformatf("f%0d_ready_low", fr), bad_rdy, 0);
        chk($sformatf("f%0d_busy_high", fr), bad_busy, 0);
        chk($sformatf("f%0d_no_early_done", fr), bad_done, 0);
        fr++;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         mode;
        logic [7:0] nxt;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [7:0] d, nxt, saved;
        int         mode;
        bit         pending;

        vt[0] = '{8'h41, 1'b0, 0, 8'h00};
        vt[1] = '{8'h55, 1'b0, 1, 8'hAA};
        vt[2] = '{8'hAA, 1'b0, 0, 8'h00};
        vt[3] = '{8'h07, 1'b1, 0, 8'h00};
        vt[4] = '{8'h03, 1'b0, 0, 8'h00};
        vt[5] = '{8'h00, 1'b0, 0, 8'h00};
        vt[6] = '{8'hFF, 1'b0, 0, 8'h00};
        vt[7] = '{8'h80, 1'b1, 2, 8'h00};
        vt[8] = '{8'h0D, 1'b1, 0, 8'h00};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_txd", TxD, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        reset = 1'b0;
        idle_check(200, "idle_after_reset");

        // Directed vectors
        pending = 1'b0;
        foreach (vt[i]) begin
            if (!pending) start_frame(vt[i].data);
            run_frame(vt[i].data, vt[i].par, vt[i].mode, vt[i].nxt);
            pending = (vt[i].mode == 1);
            if (vt[i].mode == 2) idle_check(3 * BD, "ignored_byte");
        end

        // Asynchronous abort during data bit 3 of 0xF0 (line low there)
        start_frame(8'hF0);
        tx_valid = 1'b0;
        repeat (4 * BD + BD / 2) tick();
        chk("abort_pre_txd", TxD, 0);
        #1 reset = 1'b1;
        #1;
        chk("abort_txd", TxD, 1);
        chk("abort_ready", tx_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", tx_done, 0);
        #1 reset = 1'b0;
        tick();
        idle_check(2 * BD, "idle_after_abort");
        start_frame(8'h0D);
        run_frame(8'h0D, 1'b1, 0, 8'h00);

        // Randomized traffic with optional back-to-back chaining
        pending = 1'b0;
        saved   = 8'h00;
        for (int n = 0; n < 20; n++) begin
            nxt  = 8'($urandom);
            mode = int'($urandom_range(0, 1));
            if (pending) begin
                d = saved;
            end else begin
                d = 8'($urandom);
                repeat ($urandom_range(0, 4)) tick();
                start_frame(d);
            end
            run_frame(d, 1'($countones(d) % 2), mode, nxt);
            pending = (mode == 1);
            saved   = nxt;
        end
        if (pending) run_frame(saved, 1'($countones(saved) % 2), 0, 8'h00);
        idle_check(BD, "final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
